// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array front end: sizes, output latency,
// feeder state encoding and the border tap mask helper.
package sa_pkg;

    localparam int unsigned LINE_BUF_LEN = 56;
    localparam int unsigned NUM_PE       = 10;
    localparam int unsigned SA_OUT_LAT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } feeder_state_e;

    // PE taps that fall outside the image on each border (PE 9 is the 1x1 tap)
    localparam logic [NUM_PE-1:0] TOP_TAPS    = 10'h1C0;
    localparam logic [NUM_PE-1:0] BOTTOM_TAPS = 10'h007;
    localparam logic [NUM_PE-1:0] LEFT_TAPS   = 10'h124;
    localparam logic [NUM_PE-1:0] RIGHT_TAPS  = 10'h049;

    function automatic logic [NUM_PE-1:0] border_mask(
        input logic top,
        input logic bottom,
        input logic left,
        input logic right
    );
        logic [NUM_PE-1:0] m;
        m = '1;
        if (top)    m = m & ~TOP_TAPS;
        if (bottom) m = m & ~BOTTOM_TAPS;
        if (left)   m = m & ~LEFT_TAPS;
        if (right)  m = m & ~RIGHT_TAPS;
        return m;
    endfunction

endpackage

// File: rtl/sa_pos_cnt.sv
// Push/row/col position tracker: center-valid flag, border mask and the
// output-latency valid delay line, all advanced only on pipeline pushes.
module sa_pos_cnt
    import sa_pkg::*;
#(
    parameter int unsigned IMG_W = 56,
    parameter int unsigned IMG_H = 56,
    parameter int unsigned CNT_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    output logic [CNT_W-1:0]  q,
    output logic              center_valid,
    output logic [NUM_PE-1:0] pe_mask,
    output logic              valid_dly
);
    localparam int unsigned HW = IMG_W * IMG_H;

    logic [CNT_W-1:0]      row;
    logic [CNT_W-1:0]      col;
    logic [SA_OUT_LAT-1:0] vld_sr;

    // center lags the push index by one line plus one pixel
    assign center_valid = (q >= CNT_W'(IMG_W + 1)) && (q < CNT_W'(HW + IMG_W + 1));
    assign valid_dly    = vld_sr[SA_OUT_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            row    <= '0;
            col    <= '0;
            vld_sr <= '0;
        end else if (clear) begin
            q      <= '0;
            row    <= '0;
            col    <= '0;
            vld_sr <= '0;
        end else if (en) begin
            q      <= q + CNT_W'(1);
            vld_sr <= {vld_sr[SA_OUT_LAT-2:0], center_valid};
            if (center_valid) begin
                if (col == CNT_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == CNT_W'(IMG_H - 1)) ? '0 : row + CNT_W'(1);
                end else begin
                    col <= col + CNT_W'(1);
                end
            end
        end
    end

`ifdef SA_FEEDER_PAD_EN
    assign pe_mask = border_mask(row == '0, row == CNT_W'(IMG_H - 1),
                                 col == '0, col == CNT_W'(IMG_W - 1));
`else
    assign pe_mask = '1;
`endif

endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: loads weight banks and streams one feature map into the systolic array.
// Define SA_FEEDER_PAD_EN to mask border taps (zero-padded "same" convolution).
module sa_feeder #(
    parameter int unsigned LINE_BUF_LEN = sa_pkg::LINE_BUF_LEN,
    parameter int unsigned IMG_H        = 56
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_start,
    input  logic [1:0]                load_bank,
    input  logic                      run_start,
    input  logic [1:0]                run_bank,
    output logic                      busy,
    output logic                      done,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [7:0]                w_data,
    input  logic                      px_valid,
    output logic                      px_ready,
    input  logic [7:0]                px_data,
    output logic                      pipe_en,
    output logic [sa_pkg::NUM_PE-1:0] pe_en,
    output logic [7:0]                weight_load,
    output logic [sa_pkg::NUM_PE-1:0] weight_load_en,
    output logic [1:0]                weight_load_sel,
    output logic [1:0]                weight_sel,
    output logic [7:0]                imap_in,
    output logic                      out_valid
);
    import sa_pkg::NUM_PE;
    import sa_pkg::feeder_state_e;
    import sa_pkg::ST_IDLE;
    import sa_pkg::ST_LOAD;
    import sa_pkg::ST_STREAM;
    import sa_pkg::ST_FLUSH;

    localparam int unsigned HW        = LINE_BUF_LEN * IMG_H;
    localparam int unsigned CNT_W     = $clog2(HW + LINE_BUF_LEN + 6);
    localparam int unsigned LAST_PUSH = HW + LINE_BUF_LEN + 4;
    localparam int unsigned BEAT_W    = $clog2(NUM_PE);

    feeder_state_e     state_q, state_d;
    logic [1:0]        load_bank_q;
    logic [1:0]        run_bank_q;
    logic [BEAT_W-1:0] beat_q;
    logic              done_q;

    logic [CNT_W-1:0]  q;
    logic              center_valid;
    logic              valid_dly;
    logic [NUM_PE-1:0] pe_mask;

    logic w_xfer, load_last, stream_last, flush_last;

    assign w_xfer      = (state_q == ST_LOAD) && w_valid;
    assign load_last   = w_xfer && (beat_q == BEAT_W'(NUM_PE - 1));
    assign stream_last = (state_q == ST_STREAM) && px_valid && (q == CNT_W'(HW - 1));
    assign flush_last  = (state_q == ST_FLUSH) && (q == CNT_W'(LAST_PUSH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // command latches, beat counter and the registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_bank_q <= '0;
            run_bank_q  <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= load_last || flush_last;
            if (state_q == ST_IDLE) begin
                beat_q <= '0;
                if (load_start)     load_bank_q <= load_bank;
                else if (run_start) run_bank_q  <= run_bank;
            end else if (w_xfer) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        w_ready         = 1'b0;
        px_ready        = 1'b0;
        pipe_en         = 1'b0;
        weight_load     = '0;
        weight_load_en  = '0;
        weight_load_sel = '0;
        weight_sel      = '0;
        imap_in         = '0;
        case (state_q)
            ST_IDLE: begin
                if (load_start)     state_d = ST_LOAD;
                else if (run_start) state_d = ST_STREAM;
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    weight_load     = w_data;
                    weight_load_en  = NUM_PE'(1) << beat_q;
                    weight_load_sel = load_bank_q;
                end
                if (load_last) state_d = ST_IDLE;
            end
            ST_STREAM: begin
                px_ready   = 1'b1;
                pipe_en    = px_valid;
                weight_sel = run_bank_q;
                if (px_valid) imap_in = px_data;
                if (stream_last) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                pipe_en    = 1'b1;
                weight_sel = run_bank_q;
                if (flush_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sa_pos_cnt #(
        .IMG_W (LINE_BUF_LEN),
        .IMG_H (IMG_H),
        .CNT_W (CNT_W)
    ) u_pos (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (state_q == ST_IDLE),
        .en           (pipe_en),
        .q            (q),
        .center_valid (center_valid),
        .pe_mask      (pe_mask),
        .valid_dly    (valid_dly)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign pe_en     = (pipe_en && center_valid) ? pe_mask : '0;
    assign out_valid = pipe_en && valid_dly;

endmodule

// File: tb/tb_sa_feeder.sv
// Randomized self-checking bench for sa_feeder on a 4x4 image against a
// push-index model of the frame; build with SA_FEEDER_PAD_EN for padded masks.
module tb_sa_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int HW = W * H;

    localparam int M_IDLE = 0, M_LOAD = 1, M_STREAM = 2, M_FLUSH = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start, run_start, w_valid, px_valid;
    logic [1:0] load_bank, run_bank;
    logic [7:0] w_data, px_data;
    logic       busy, done, w_ready, px_ready, pipe_en, out_valid;
    logic [9:0] pe_en, weight_load_en;
    logic [7:0] weight_load, imap_in;
    logic [1:0] weight_load_sel, weight_sel;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sa_feeder #(.LINE_BUF_LEN(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_bank(load_bank),
        .run_start(run_start), .run_bank(run_bank),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .pipe_en(pipe_en), .pe_en(pe_en),
        .weight_load(weight_load), .weight_load_en(weight_load_en),
        .weight_load_sel(weight_load_sel), .weight_sel(weight_sel),
        .imap_in(imap_in), .out_valid(out_valid)
    );

    // expected PE enables for the push with index p
    function automatic logic [9:0] exp_pe(input int p);
        int c;
        logic [9:0] m;
        c = p - (W + 1);
        if (c < 0 || c >= HW) return 10'h000;
        m = 10'h3FF;
`ifdef SA_FEEDER_PAD_EN
        begin
            int r, k;
            r = c / W;
            k = c % W;
            if (r == 0)     begin m[8] = 1'b0; m[7] = 1'b0; m[6] = 1'b0; end
            if (r == H - 1) begin m[2] = 1'b0; m[1] = 1'b0; m[0] = 1'b0; end
            if (k == 0)     begin m[8] = 1'b0; m[5] = 1'b0; m[2] = 1'b0; end
            if (k == W - 1) begin m[6] = 1'b0; m[3] = 1'b0; m[0] = 1'b0; end
        end
`endif
        return m;
    endfunction

    function automatic logic exp_ov(input int p);
        return (p - (W + 5) >= 0) && (p - (W + 5) < HW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // model state
    int         m_mode = M_IDLE;
    int         m_beat, m_push, m_xfers, m_flush, m_kind;
    logic       m_done = 1'b0;
    logic [1:0] m_lbank, m_rbank;
    int         obs_pipe, obs_ov, obs_beats;
    logic       seen_ov;

    logic       e_pipe, e_ov;
    logic [9:0] e_pe, e_wle;
    logic [7:0] e_wl, e_img;
    logic [1:0] e_wls, e_ws;
    logic       n_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_done = 1'b0;
        end
        e_pipe = (m_mode == M_STREAM && px_valid) || m_mode == M_FLUSH;
        e_wl = '0; e_wle = '0; e_wls = '0;
        if (m_mode == M_LOAD && w_valid) begin
            e_wl  = w_data;
            e_wle = 10'(1 << m_beat);
            e_wls = m_lbank;
        end
        e_ws  = (m_mode == M_STREAM || m_mode == M_FLUSH) ? m_rbank : 2'd0;
        e_img = (m_mode == M_STREAM && px_valid) ? px_data : 8'd0;
        e_pe  = e_pipe ? exp_pe(m_push) : 10'h000;
        e_ov  = e_pipe && exp_ov(m_push);

        chk("busy", busy, m_mode != M_IDLE);
        chk("done", done, m_done);
        chk("w_ready", w_ready, m_mode == M_LOAD);
        chk("px_ready", px_ready, m_mode == M_STREAM);
        chk("pipe_en", pipe_en, e_pipe);
        chk("pe_en", pe_en, e_pe);
        chk("out_valid", out_valid, e_ov);
        chk("weight_load", weight_load, e_wl);
        chk("weight_load_en", weight_load_en, e_wle);
        chk("weight_load_sel", weight_load_sel, e_wls);
        chk("weight_sel", weight_sel, e_ws);
        chk("imap_in", imap_in, e_img);

        if (rst_n) begin
            // hand-computed anchors on observed DUT behaviour
            if (pipe_en && obs_pipe == 5)
`ifdef SA_FEEDER_PAD_EN
                chk("pe_center0", pe_en, 10'h21B);
`else
                chk("pe_center0", pe_en, 10'h3FF);
`endif
            if (pipe_en && obs_pipe == 10) chk("pe_center5", pe_en, 10'h3FF);
            if (pipe_en && obs_pipe == 20)
`ifdef SA_FEEDER_PAD_EN
                chk("pe_center15", pe_en, 10'h3B0);
`else
                chk("pe_center15", pe_en, 10'h3FF);
`endif
            if (out_valid && !seen_ov) begin
                chk("first_out_valid_q", obs_pipe, 9);
                seen_ov = 1'b1;
            end
            if (pipe_en) obs_pipe++;
            if (out_valid) obs_ov++;
            if (weight_load_en != 10'h000) obs_beats++;
            if (m_done && m_kind == 1) begin
                chk("frame_pipe_cycles", obs_pipe, 25);
                chk("frame_out_valids", obs_ov, 16);
            end
            if (m_done && m_kind == 0) chk("load_beats", obs_beats, 10);

            n_done = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (load_start) begin
                        m_mode = M_LOAD; m_lbank = load_bank; m_beat = 0;
                        m_kind = 0; obs_beats = 0;
                    end else if (run_start) begin
                        m_mode = M_STREAM; m_rbank = run_bank; m_push = 0; m_xfers = 0;
                        m_kind = 1; obs_pipe = 0; obs_ov = 0; seen_ov = 1'b0;
                    end
                end
                M_LOAD: if (w_valid) begin
                    m_beat++;
                    if (m_beat == 10) begin m_mode = M_IDLE; n_done = 1'b1; end
                end
                M_STREAM: if (px_valid) begin
                    m_push++; m_xfers++;
                    if (m_xfers == HW) begin m_mode = M_FLUSH; m_flush = 0; end
                end
                default: begin
                    m_push++; m_flush++;
                    if (m_flush == W + 5) begin m_mode = M_IDLE; n_done = 1'b1; end
                end
            endcase
            m_done = n_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) begin
            px_valid = 1'($urandom_range(0, 1));
            px_data  = 8'($urandom);
            tick();
        end
        if (busy) begin
            $display("FAIL wait_idle: busy still %0b after 200 cycles, expected 0", busy);
            $fatal(1);
        end
    endtask

    task automatic do_load(input logic [1:0] bank, input bit rnd);
        int k;
        load_start = 1'b1;
        load_bank  = bank;
        run_start  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        run_bank   = 2'($urandom);
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        k = 0;
        while (k < 10) begin
            w_valid    = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            w_data     = rnd ? 8'($urandom) : 8'(8'h10 + k);
            run_start  = rnd && ($urandom_range(0, 4) == 0);
            load_start = rnd && ($urandom_range(0, 4) == 0);
            load_bank  = 2'($urandom);
            if (w_valid) k++;
            tick();
        end
        w_valid = 1'b0; run_start = 1'b0; load_start = 1'b0;
        wait_idle();
    endtask

    // mode 0: no stall, 1: 3-cycle stall after 8 pixels, 2: random stalls
    task automatic do_frame(input logic [1:0] bank, input int mode);
        int n, st;
        run_start = 1'b1;
        run_bank  = bank;
        tick();
        run_start = 1'b0;
        n = 0; st = 0;
        while (n < HW) begin
            case (mode)
                0: px_valid = 1'b1;
                1: if (n == 8 && st < 3) begin px_valid = 1'b0; st++; end
                   else px_valid = 1'b1;
                default: px_valid = ($urandom_range(0, 3) != 0);
            endcase
            px_data    = 8'($urandom);
            load_start = (mode == 2) && ($urandom_range(0, 7) == 0);
            load_bank  = 2'($urandom);
            if (px_valid) n++;
            tick();
        end
        load_start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 1'b0; run_start = 1'b0; load_bank = '0; run_bank = '0;
        w_valid = 1'b0; w_data = '0; px_valid = 1'b0; px_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(); tick();

        do_load(2'd2, 1'b0);
        tick(); tick();
        do_frame(2'd1, 0);
        tick(); tick();
        do_frame(2'd3, 1);
        tick();

        // abort a frame at push index 7
        run_start = 1'b1; run_bank = 2'd2;
        tick();
        run_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            px_valid = 1'b1; px_data = 8'($urandom);
            tick();
        end
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; px_valid = 1'b0;
        tick();
        do_frame(2'd1, 0);
        tick();

        for (int i = 0; i < 6; i++) begin
            do_load(2'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            do_frame(2'($urandom), 2);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
